// File: rtl/rocketcpu_bus_scheduler.sv
// Shared Wishbone scheduler for the SERV core: round-robin ibus/dbus arbitration,
// one-hot slave decode, generated acks for ack-less slaves and a watchdog that errors out hung accesses.
module rocketcpu_bus_scheduler #(
  parameter int         TIMEOUT  = 255,
  parameter logic [6:0] AUTO_ACK = 7'b0101000
) (
  input  logic         i_wb_clk,
  input  logic         reset_n,
  input  logic [31:0]  i_ibus_adr,
  input  logic         i_ibus_cyc,
  output logic [31:0]  o_ibus_rdt,
  output logic         o_ibus_ack,
  input  logic [31:0]  i_dbus_adr,
  input  logic [31:0]  i_dbus_dat,
  input  logic [3:0]   i_dbus_sel,
  input  logic         i_dbus_we,
  input  logic         i_dbus_cyc,
  output logic [31:0]  o_dbus_rdt,
  output logic         o_dbus_ack,
  output logic [31:0]  o_wb_adr,
  output logic [31:0]  o_wb_dat,
  output logic [3:0]   o_wb_sel,
  output logic         o_wb_we,
  output logic [6:0]   o_slv_cyc,
  input  logic [6:0]   i_slv_ack,
  input  logic [223:0] i_slv_rdt,
  output logic         o_bus_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t      state_r, state_s;
  logic        grant_d_r, last_d_r;
  logic [7:0]  wd_r;
  logic        pick_d_s, grant_s, owner_cyc_s, slv_ack_s, unmapped_s, timeout_s, finish_s;
  logic [6:0]  ack_mask_s;
  logic [31:0] adr_s, slv_rdt_s, resp_rdt_s;

  // Exact register addresses take priority over the flash and audio ranges they overlap.
  function automatic logic [6:0] decode(input logic [31:0] adr);
    logic [6:0] sel;
    if (adr == 32'h0100_0000)       sel = 7'b0000100;
    else if (adr == 32'h0200_0000)  sel = 7'b0001000;
    else if (adr == 32'h0400_0000)  sel = 7'b0010000;
    else if (adr == 32'h0800_0000)  sel = 7'b0100000;
    else if (adr >= 32'h1000_0000)  sel = 7'b1000000;
    else if (adr <  32'h0000_8000)  sel = 7'b0000001;
    else if (adr >= 32'h0010_0000 && adr <= 32'h01FF_FFFF) sel = 7'b0000010;
    else                            sel = 7'b0000000;
    return sel;
  endfunction

  // Arbitration pick, effective slave ack, watchdog and response data.
  always_comb begin
    pick_d_s    = i_dbus_cyc & (~i_ibus_cyc | ~last_d_r);
    grant_s     = (state_r == IDLE) & (i_ibus_cyc | i_dbus_cyc);
    adr_s       = pick_d_s ? i_dbus_adr : i_ibus_adr;
    owner_cyc_s = grant_d_r ? i_dbus_cyc : i_ibus_cyc;
    // Generated acks fire on the first BUS cycle, when the watchdog is still zero.
    ack_mask_s  = (AUTO_ACK & {7{wd_r == 8'd0}}) | (~AUTO_ACK & i_slv_ack);
    slv_ack_s   = |(o_slv_cyc & ack_mask_s);
    unmapped_s  = (o_slv_cyc == 7'b0000000);
    timeout_s   = (wd_r == WD_LAST);
    slv_rdt_s   = 32'h0000_0000;
    for (int n = 0; n < 7; n++) begin
      if (o_slv_cyc[n]) slv_rdt_s = slv_rdt_s | i_slv_rdt[32*n +: 32];
      else              slv_rdt_s = slv_rdt_s;
    end
    if (slv_ack_s)       resp_rdt_s = slv_rdt_s;
    else if (unmapped_s) resp_rdt_s = 32'h0000_0000;
    else                 resp_rdt_s = 32'hFFFF_FFFF;
    finish_s = (state_r == BUS) & owner_cyc_s & (slv_ack_s | unmapped_s | timeout_s);
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) state_s = BUS;
        else         state_s = IDLE;
      end
      BUS: begin
        if (!owner_cyc_s)  state_s = IDLE;
        else if (finish_s) state_s = RESP;
        else               state_s = BUS;
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_wb_clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // Grant latch, slave-side request, watchdog and master responses.
  always_ff @(posedge i_wb_clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_d_r  <= 1'b0;
      last_d_r   <= 1'b0;
      wd_r       <= 8'd0;
      o_wb_adr   <= 32'h0000_0000;
      o_wb_dat   <= 32'h0000_0000;
      o_wb_sel   <= 4'h0;
      o_wb_we    <= 1'b0;
      o_slv_cyc  <= 7'b0000000;
      o_ibus_ack <= 1'b0;
      o_dbus_ack <= 1'b0;
      o_bus_err  <= 1'b0;
      o_ibus_rdt <= 32'h0000_0000;
      o_dbus_rdt <= 32'h0000_0000;
    end else begin
      o_ibus_ack <= finish_s & ~grant_d_r;
      o_dbus_ack <= finish_s & grant_d_r;
      o_bus_err  <= finish_s & ~slv_ack_s;
      if (finish_s) begin
        if (grant_d_r) o_dbus_rdt <= resp_rdt_s;
        else           o_ibus_rdt <= resp_rdt_s;
      end
      if (grant_s) begin
        grant_d_r <= pick_d_s;
        last_d_r  <= pick_d_s;
        wd_r      <= 8'd0;
        o_wb_adr  <= adr_s;
        o_wb_dat  <= pick_d_s ? i_dbus_dat : 32'h0000_0000;
        o_wb_sel  <= pick_d_s ? i_dbus_sel : 4'hF;
        o_wb_we   <= pick_d_s & i_dbus_we;
        o_slv_cyc <= decode(adr_s);
      end else if (state_r == BUS && state_s != BUS) begin
        o_slv_cyc <= 7'b0000000;
      end else if (state_r == BUS) begin
        wd_r <= wd_r + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_rocketcpu_bus_scheduler.sv
// Randomized scoreboard bench for rocketcpu_bus_scheduler: a spec-level model predicts
// each master response (data, error, ack cycle, select) and a monitor checks them as acks appear.
module tb_rocketcpu_bus_scheduler;
  localparam int         TO = 4;
  localparam logic [6:0] AA = 7'b0101000;

  logic         clk = 1'b0, reset_n = 1'b0;
  logic [31:0]  i_ibus_adr = 32'h0, i_dbus_adr = 32'h0, i_dbus_dat = 32'h0;
  logic         i_ibus_cyc = 1'b0, i_dbus_cyc = 1'b0, i_dbus_we = 1'b0;
  logic [3:0]   i_dbus_sel = 4'h0;
  logic [31:0]  o_ibus_rdt, o_dbus_rdt, o_wb_adr, o_wb_dat;
  logic         o_ibus_ack, o_dbus_ack, o_wb_we, o_bus_err;
  logic [3:0]   o_wb_sel;
  logic [6:0]   o_slv_cyc;
  logic [6:0]   i_slv_ack = 7'b0;
  logic [223:0] rdt_g = 224'h0;

  rocketcpu_bus_scheduler #(.TIMEOUT(TO), .AUTO_ACK(AA)) dut (
    .i_wb_clk(clk), .reset_n(reset_n),
    .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc), .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
    .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel), .i_dbus_we(i_dbus_we),
    .i_dbus_cyc(i_dbus_cyc), .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
    .o_slv_cyc(o_slv_cyc), .i_slv_ack(i_slv_ack), .i_slv_rdt(rdt_g), .o_bus_err(o_bus_err));

  always #5 clk = ~clk;

  logic [31:0] cnt = 32'd0;
  always @(posedge clk) cnt <= cnt + 32'd1;

  typedef struct packed {
    logic [31:0] rdt; logic err; logic [31:0] at; logic [6:0] sel; logic [31:0] selcnt;
    logic [31:0] adr; logic we; logic [3:0] be; logic [31:0] dat; logic chk_dat;
  } exp_t;

  exp_t q_i[$], q_d[$];
  int   checks = 0, errors = 0;
  int   lat_g = 1;
  bit   last_d = 1'b0;   // who the scheduler served most recently (1 = dbus)

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cnt);
    end
  endtask

  // Address map: -1 means unmapped.
  function automatic int ref_slave(input logic [31:0] a);
    case (a)
      32'h0100_0000: return 2;
      32'h0200_0000: return 3;
      32'h0400_0000: return 4;
      32'h0800_0000: return 5;
      default: ;
    endcase
    if (a >= 32'h1000_0000) return 6;
    if (a < 32'h0000_8000) return 0;
    if (a >= 32'h0010_0000 && a <= 32'h01FF_FFFF) return 1;
    return -1;
  endfunction

  // Expected outcome of one granted access whose cycle 0 is t0; slave acks on its lat-th select cycle.
  function automatic exp_t build(input bit d, input logic [31:0] adr, input logic we, input logic [3:0] be,
                                 input logic [31:0] dat, input int lat, input logic [31:0] t0,
                                 input logic [223:0] bus);
    exp_t e;
    int   s, k;
    s = ref_slave(adr);
    e.adr = adr; e.we = d ? we : 1'b0; e.be = d ? be : 4'hF; e.dat = dat; e.chk_dat = d;
    if (s < 0) begin
      k = 1; e.rdt = 32'h0; e.err = 1'b1; e.sel = 7'h0; e.selcnt = 32'd0;
    end else begin
      e.sel = 7'h0; e.sel[s] = 1'b1;
      if (AA[s]) begin
        k = 1; e.rdt = bus[32*s +: 32]; e.err = 1'b0;
      end else if (lat > TO) begin
        k = TO; e.rdt = 32'hFFFF_FFFF; e.err = 1'b1;
      end else begin
        k = lat; e.rdt = bus[32*s +: 32]; e.err = 1'b0;
      end
      e.selcnt = 32'(k);
    end
    e.at = t0 + 32'(k) + 32'd1;
    return e;
  endfunction

  // Slave side: the selected slave acks on its lat_g-th select cycle; everything else is random noise.
  int scnt [7];
  always @(negedge clk) begin
    for (int n = 0; n < 7; n++) begin
      scnt[n] <= o_slv_cyc[n] ? scnt[n] + 1 : 0;
      if (o_slv_cyc[n] && !AA[n]) i_slv_ack[n] <= (scnt[n] + 1 == lat_g);
      else                        i_slv_ack[n] <= 1'($urandom_range(0, 1));
    end
  end

  logic [6:0]  sel_seen = 7'h0;
  logic [31:0] sel_cnt = 32'd0;
  bit          sel_bad = 1'b0;

  task automatic pop_check(input bit d);
    exp_t e;
    if ((d && q_d.size() == 0) || (!d && q_i.size() == 0)) begin
      if (d) chk("unexpected_dbus_ack", 32'd1, 32'd0);
      else   chk("unexpected_ibus_ack", 32'd1, 32'd0);
      return;
    end
    if (d) begin e = q_d.pop_front(); chk("dbus_rdt", o_dbus_rdt, e.rdt); end
    else   begin e = q_i.pop_front(); chk("ibus_rdt", o_ibus_rdt, e.rdt); end
    chk("bus_err", 32'(o_bus_err), 32'(e.err));
    chk("ack_cycle", cnt, e.at);
    chk("slv_sel", sel_bad ? 32'hBAD0 : 32'(sel_seen), 32'(e.sel));
    chk("sel_cycles", sel_cnt, e.selcnt);
    chk("wb_adr", o_wb_adr, e.adr);
    chk("wb_we", 32'(o_wb_we), 32'(e.we));
    chk("wb_sel", 32'(o_wb_sel), 32'(e.be));
    if (e.chk_dat) chk("wb_dat", o_wb_dat, e.dat);
  endtask

  // Monitor: pop and compare on every master ack, track the select seen for the current access.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        sel_seen = 7'h0; sel_cnt = 32'd0; sel_bad = 1'b0;
      end else begin
        if (o_ibus_ack) pop_check(1'b0);
        if (o_dbus_ack) pop_check(1'b1);
        if (o_bus_err && !o_ibus_ack && !o_dbus_ack) chk("err_without_ack", 32'd1, 32'd0);
        if (o_ibus_ack || o_dbus_ack || o_slv_cyc == 7'h0) begin
          sel_seen = 7'h0; sel_cnt = 32'd0; sel_bad = 1'b0;
        end else begin
          if (sel_cnt == 32'd0) sel_seen = o_slv_cyc;
          else if (o_slv_cyc != sel_seen) sel_bad = 1'b1;
          if ($countones(o_slv_cyc) != 1) sel_bad = 1'b1;
          sel_cnt = sel_cnt + 32'd1;
        end
      end
    end
  end

  task automatic outs_zero();
    chk("zero_slv_cyc", 32'(o_slv_cyc), 32'd0);
    chk("zero_ack_err", {29'd0, o_ibus_ack, o_dbus_ack, o_bus_err}, 32'd0);
    chk("zero_ibus_rdt", o_ibus_rdt, 32'd0);
    chk("zero_dbus_rdt", o_dbus_rdt, 32'd0);
    chk("zero_wb_adr", o_wb_adr, 32'd0);
    chk("zero_wb_ctl", {27'd0, o_wb_we, o_wb_sel}, 32'd0);
  endtask

  task automatic new_rdt();
    for (int n = 0; n < 7; n++) rdt_g[32*n +: 32] = $urandom;
  endtask

  function automatic logic [31:0] rand_adr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 8))
      0: r = 32'h0100_0000;
      1: r = 32'h0200_0000;
      2: r = 32'h0400_0000;
      3: r = 32'h0800_0000;
      4: r = r | 32'h1000_0000;
      5: r = r & 32'h0000_7FFC;
      6: r = 32'h0010_0000 + (r % 32'h01F0_0000);
      7: r = 32'h0000_8000 + (r % 32'h000F_8000);
      default: r = 32'h0200_0000 + (r % 32'h0E00_0000);
    endcase
    return r;
  endfunction

  task automatic run_txn(input bit d, input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] be, input int lat);
    bit got = 1'b0;
    @(negedge clk);
    new_rdt();
    lat_g = lat;
    if (d) q_d.push_back(build(1'b1, adr, we, be, dat, lat, cnt, rdt_g));
    else   q_i.push_back(build(1'b0, adr, we, be, dat, lat, cnt, rdt_g));
    last_d = d;
    if (d) begin
      i_dbus_adr = adr; i_dbus_dat = dat; i_dbus_sel = be; i_dbus_we = we; i_dbus_cyc = 1'b1;
      i_ibus_adr = $urandom;
    end else begin
      i_ibus_adr = adr; i_ibus_cyc = 1'b1;
      i_dbus_adr = $urandom; i_dbus_dat = $urandom; i_dbus_we = 1'b1; i_dbus_sel = 4'h3;
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (d ? o_dbus_ack : o_ibus_ack) begin got = 1'b1; break; end
    end
    i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0;
    if (!got) begin chk("ack_wait_expired", 32'd0, 32'd1); q_i.delete(); q_d.delete(); end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic run_tie(input logic [31:0] adr_i, input logic [31:0] adr_d, input int lat);
    exp_t ew, el;
    bit   win_d, done_i = 1'b0, done_d = 1'b0;
    logic        we = 1'($urandom_range(0, 1));
    logic [31:0] dat = $urandom;
    logic [3:0]  be = 4'($urandom);
    @(negedge clk);
    new_rdt();
    lat_g = lat;
    win_d = !last_d;
    if (win_d) begin
      ew = build(1'b1, adr_d, we, be, dat, lat, cnt, rdt_g);
      el = build(1'b0, adr_i, 1'b0, 4'h0, 32'h0, lat, ew.at + 32'd1, rdt_g);
      q_d.push_back(ew); q_i.push_back(el);
    end else begin
      ew = build(1'b0, adr_i, 1'b0, 4'h0, 32'h0, lat, cnt, rdt_g);
      el = build(1'b1, adr_d, we, be, dat, lat, ew.at + 32'd1, rdt_g);
      q_i.push_back(ew); q_d.push_back(el);
    end
    last_d = !win_d;
    i_ibus_adr = adr_i; i_dbus_adr = adr_d; i_dbus_dat = dat; i_dbus_sel = be; i_dbus_we = we;
    i_ibus_cyc = 1'b1; i_dbus_cyc = 1'b1;
    for (int i = 0; i < 600 && !(done_i && done_d); i++) begin
      @(negedge clk);
      if (o_ibus_ack) begin done_i = 1'b1; i_ibus_cyc = 1'b0; end
      if (o_dbus_ack) begin done_d = 1'b1; i_dbus_cyc = 1'b0; end
    end
    i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0;
    if (!(done_i && done_d)) begin chk("tie_wait_expired", 32'd0, 32'd1); q_i.delete(); q_d.delete(); end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic run_abort();
    int acks = 0;
    @(negedge clk);
    lat_g = 100;
    i_dbus_adr = 32'h0000_0020; i_dbus_we = 1'b0; i_dbus_sel = 4'hF; i_dbus_cyc = 1'b1;
    last_d = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_sel_cycle2", 32'(o_slv_cyc), 32'h01);
    i_dbus_cyc = 1'b0;
    @(negedge clk);
    chk("abort_idle_cycle3", 32'(o_slv_cyc), 32'h00);
    for (int i = 0; i < 4; i++) begin
      acks += int'(o_dbus_ack) + int'(o_ibus_ack) + int'(o_bus_err);
      @(negedge clk);
    end
    chk("abort_no_ack", 32'(acks), 32'd0);
  endtask

  task automatic run_mid_reset();
    @(negedge clk);
    lat_g = 100;
    i_dbus_adr = 32'h0020_0000; i_dbus_we = 1'b1; i_dbus_sel = 4'hF; i_dbus_cyc = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_reset_sel", 32'(o_slv_cyc), 32'h02);
    #2 reset_n = 1'b0;
    #1 outs_zero();
    i_dbus_cyc = 1'b0;
    q_i.delete(); q_d.delete();
    last_d = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    outs_zero();
    reset_n = 1'b1;
    last_d = 1'b0;

    run_tie(32'h0010_0000, 32'h0400_0000, 1);
    run_txn(1'b1, 32'h0000_0010, 1'b0, 32'h0, 4'hF, 3);
    run_txn(1'b1, 32'h0200_0000, 1'b1, 32'h1, 4'hF, 5);
    run_txn(1'b1, 32'h0100_0000, 1'b1, 32'hA5A5_0001, 4'h3, 2);
    run_txn(1'b1, 32'h0000_9000, 1'b0, 32'h0, 4'hF, 1);
    run_txn(1'b0, 32'h0010_0000, 1'b0, 32'h0, 4'h0, 100);
    run_txn(1'b0, 32'h0010_0000, 1'b0, 32'h0, 4'h0, 4);
    run_txn(1'b0, 32'h0800_0000, 1'b0, 32'h0, 4'h0, 100);
    run_abort();
    run_tie(32'h0000_0100, 32'h1234_5678, 2);
    run_mid_reset();
    run_tie(32'h0010_0000, 32'h0400_0000, 1);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0) run_tie(rand_adr(), rand_adr(), $urandom_range(1, 6));
      else run_txn(1'($urandom_range(0, 1)), rand_adr(), 1'($urandom_range(0, 1)), $urandom,
                   4'($urandom), $urandom_range(1, 6));
    end

    repeat (5) @(negedge clk);
    chk("queue_left", 32'(q_i.size() + q_d.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
